light_pwm_driver: RTL and testbench
===================================

Name: light_pwm_driver

Overview:
- Output-side counterpart to the light sensor input path. The sensor brings a light level into the FPGA; this block drives a light (LED/backlight pin) out of it.
- Accepts a target brightness over a valid/ready command handshake.
- Ramps the current brightness toward the target one step at a time.
- Emits a glitch-free PWM waveform on a single output pin.
- Sits between the game/control FSM and the board LED pin.

Parameters:
- PWM_BITS, 8, width of brightness level; PWM period = 2^PWM_BITS-1 clocks.
- RAMP_DIV, 50000, clocks per one-LSB brightness step while ramping (must be >=1).
- BLINK_DIV, 25000000, clocks per blink half-period (used only with optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  target level offered.
- cmd_level  in  PWM_BITS  requested target brightness.
- cmd_ready  out  1  block can accept a command.
- led_pwm  out  1  PWM drive to LED pin, registered.
- level  out  PWM_BITS  current (ramped) brightness.
- busy  out  1  ramp in progress.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). Reset clears all state immediately, including mid-ramp: level=0, led_pwm=0, busy=0, cmd_ready=1, pwm counter=0, step counter=0, FSM=IDLE.
- PWM counter pwm_cnt: free-running 0..2^PWM_BITS-2, wraps to 0.
- duty register: loaded from level only when pwm_cnt==0, so period-boundary updates only and no mid-period glitches.
- led_pwm <= (pwm_cnt < duty), registered, giving 1-clock latency from the counter.
  - duty=0 gives constant 0.
  - duty=2^PWM_BITS-1 gives constant 1.
- FSM states: IDLE, RAMP.
  - cmd_ready = (state==IDLE); busy = (state==RAMP).
- IDLE, on cmd_valid&&cmd_ready:
  - latch target <= cmd_level.
  - If cmd_level==level: stay IDLE, no visible change.
  - Otherwise: go to RAMP and set step counter to RAMP_DIV-1.
- RAMP: cmd_valid ignored (not accepted, no queueing). Step counter decrements each clock. At 0:
  - level steps by one toward target (+1 if target>level, else -1);
  - counter reloads to RAMP_DIV-1.
  - If the new level==target, go to IDLE in the same edge.
- Ramp duration = |target-level|*RAMP_DIV clocks from the acceptance edge to the edge setting the final level.
- Arithmetic: level never wraps. Stepping only toward target keeps it within 0..2^PWM_BITS-1.
- RAMP_DIV==1: one step every clock.
- Command accepted on the same edge that returns to IDLE: impossible, since cmd_ready is 0 during that cycle. The next command is accepted one cycle later at the earliest.

Optional Feature:
- Macro LIGHT_PWM_BLINK_EN.
- When defined:
  - extra input blink (1 bit) and a blink counter of width clog2(BLINK_DIV).
  - While blink=1, a phase bit toggles every BLINK_DIV clocks; led_pwm is forced 0 during the off phase.
  - The phase resets to the on phase when blink falls.
  - Ramp, level and handshake are unaffected.
- When undefined: no blink port, no counter, behaviour exactly as above.

Decomposition:
- Package light_pkg holds:
  - FSM state enum (IDLE, RAMP);
  - default constants for PWM_BITS, RAMP_DIV, BLINK_DIV;
  - a shared light-level typedef sized by PWM_BITS, also used by the sensor-input side.
- One sub-module, pwm_gen: counter, duty latch at period boundary, comparator output register.
- The ramp FSM stays in light_pwm_driver.

Test Plan:
All cases use PWM_BITS=4 (period 15) and RAMP_DIV=2.
- Reset, then no command: led_pwm=0 for 100 clocks; cmd_ready=1, level=0, busy=0.
- Command level 15 from 0: accepted in one cycle. Then:
  - busy=1 for exactly 30 clocks and level increments every 2 clocks;
  - after the next period boundary, led_pwm is constant 1.
- Hold at level 5 (in IDLE): measure one 15-clock period; led_pwm high exactly 5 clocks, low 10, aligned to pwm_cnt 0..4.
- Command 3 while ramping 0->10: cmd_ready=0, so the command is not accepted. The ramp ends at 10, then the retried 3 ramps down in 14 clocks.
- Command equal to the current level (7->7): accepted, busy stays 0, led_pwm pattern unchanged.
- Assert rst mid-ramp (level=6): outputs zero asynchronously, before the next clk edge. After release, cmd_ready=1 and level=0.
- With LIGHT_PWM_BLINK_EN, BLINK_DIV=4, level 15, blink=1: led_pwm alternates 4 clocks high, 4 low.

Source files
------------

// File: rtl/light_pwm_driver_pkg.sv
// Shared light-path types and defaults; the level typedef is also used by the sensor-input side.
// Pure declarations: no logic, latency or backpressure of its own.
package light_pkg;

  localparam int unsigned PWM_BITS_DEF  = 8;
  localparam int unsigned RAMP_DIV_DEF  = 50000;
  localparam int unsigned BLINK_DIV_DEF = 25000000;

  typedef logic [PWM_BITS_DEF-1:0] light_level_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_t;

  // Counter width that still holds n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/light_pwm_driver_pwm_gen.sv
// PWM generator: free-running 0..2^PWM_BITS-2 counter, duty captured at period start, registered output.
// Latency: one clock from counter to pin; no backpressure (free-running).
module pwm_gen
  import light_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] level_i,
  input  logic                gate_i,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] cnt_q,  cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q,  pwm_d;

  // The first slot of a period already compares against the freshly captured level,
  // so every period uses exactly one duty value.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    duty_d = (cnt_q == '0) ? level_i : duty_q;
    pwm_d  = gate_i && (cnt_q < duty_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/light_pwm_driver.sv
// LED brightness driver: valid/ready target, one-LSB-per-RAMP_DIV ramp, PWM pin; optional blink via LIGHT_PWM_BLINK_EN.
// Latency: ramp |target-level|*RAMP_DIV clocks; cmd_ready low for the whole ramp (commands dropped, not queued).
module light_pwm_driver
  import light_pkg::*;
#(
  parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
  parameter int unsigned RAMP_DIV  = RAMP_DIV_DEF
`ifdef LIGHT_PWM_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV = BLINK_DIV_DEF
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [PWM_BITS-1:0] cmd_level,
  output logic                cmd_ready,
`ifdef LIGHT_PWM_BLINK_EN
  input  logic                blink,
`endif
  output logic                led_pwm,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int unsigned      SW          = cnt_width(RAMP_DIV);
  localparam logic [SW-1:0]    STEP_RELOAD = SW'(RAMP_DIV - 1);

  ramp_state_t         state_q;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] target_q;
  logic [SW-1:0]       step_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic [PWM_BITS-1:0] level_d;
  logic                pwm_gate;

  // Only ever moves toward target, so it cannot wrap past either rail.
  assign level_d = (target_q > level_q) ? level_q + 1'b1 : level_q - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      target_q    <= '0;
      step_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            target_q <= cmd_level;
            if (cmd_level != level_q) begin
              state_q     <= ST_RAMP;
              step_q      <= STEP_RELOAD;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        ST_RAMP: begin
          if (step_q == '0) begin
            level_q <= level_d;
            step_q  <= STEP_RELOAD;
            if (level_d == target_q) begin
              state_q     <= ST_IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else begin
            step_q <= step_q - 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef LIGHT_PWM_BLINK_EN
  localparam int unsigned      BW         = cnt_width(BLINK_DIV);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          phase_on_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (!blink) begin
      blink_cnt_q <= '0;
      phase_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      phase_on_q  <= ~phase_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Dropping blink releases the gate on the very next PWM sample.
  assign pwm_gate = !blink || phase_on_q;
`else
  assign pwm_gate = 1'b1;
`endif

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk     (clk),
    .rst     (rst),
    .level_i (level_q),
    .gate_i  (pwm_gate),
    .pwm_o   (led_pwm)
  );

  assign level     = level_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_light_pwm_driver.sv
// Self-checking bench for light_pwm_driver (PWM_BITS=4, RAMP_DIV=2) against a schedule-based reference model.
module tb_light_pwm_driver;

  localparam int PB  = 4;
  localparam int RD  = 2;
  localparam int PER = 15;
  localparam int BD  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [PB-1:0] cmd_level = '0;
  logic          cmd_ready;
  logic          led_pwm;
  logic [PB-1:0] level;
  logic          busy;
`ifdef LIGHT_PWM_BLINK_EN
  logic          blink = 1'b0;
`endif

  always #5 clk = ~clk;

  light_pwm_driver #(
    .PWM_BITS (PB),
    .RAMP_DIV (RD)
`ifdef LIGHT_PWM_BLINK_EN
    ,
    .BLINK_DIV(BD)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_level (cmd_level),
    .cmd_ready (cmd_ready),
`ifdef LIGHT_PWM_BLINK_EN
    .blink     (blink),
`endif
    .led_pwm   (led_pwm),
    .level     (level),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: edge count since reset release, plus the last accepted ramp
  // (edge, start level, target). Level after edge k follows from plain arithmetic.
  int n;
  int acc_edge, acc_from, acc_to;
  int lvl_hist[$];
  int blink_edge;
  logic blink_prev;

  function automatic int m_dist();
    return (acc_to > acc_from) ? acc_to - acc_from : acc_from - acc_to;
  endfunction

  function automatic int m_level(input int k);
    int steps;
    steps = (k - acc_edge) / RD;
    if (steps > m_dist()) steps = m_dist();
    return (acc_to > acc_from) ? acc_from + steps : acc_from - steps;
  endfunction

  function automatic bit m_busy(input int k);
    return (k >= acc_edge) && (k < acc_edge + m_dist() * RD);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    acc_edge = 0;
    acc_from = 0;
    acc_to = 0;
    lvl_hist.delete();
    lvl_hist.push_back(0);
    blink_edge = 0;
    blink_prev = 1'b0;
  endtask

  // One clock: advance model on the edge, then compare every output 1ns later.
  task automatic tick();
    logic v, bl;
    int lv, c, d, exp_led;
    v  = cmd_valid;
    lv = int'(cmd_level);
    bl = 1'b0;
`ifdef LIGHT_PWM_BLINK_EN
    bl = blink;
`endif
    @(posedge clk);
    n++;
    if (v && !m_busy(n - 1) && lv != m_level(n - 1)) begin
      acc_from = m_level(n - 1);
      acc_to   = lv;
      acc_edge = n;
    end
    lvl_hist.push_back(m_level(n));
    c = (n - 1) % PER;
    d = lvl_hist[n - 1 - c];
    exp_led = (c < d) ? 1 : 0;
    if (bl && !blink_prev) blink_edge = n;
    blink_prev = bl;
    if (bl && (((n - blink_edge) / BD) % 2 == 1)) exp_led = 0;
    #1;
    check("level", int'(level), m_level(n));
    check("busy", int'(busy), int'(m_busy(n)));
    check("cmd_ready", int'(cmd_ready), int'(!m_busy(n)));
    check("led_pwm", int'(led_pwm), exp_led);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_level", int'(level), 0);
    check("rst_led", int'(led_pwm), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input int lv);
    cmd_valid = 1'b1;
    cmd_level = 4'(lv);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) tick();
    check("idle_timeout", int'(busy), 0);
  endtask

  int cnt;

  initial begin
    model_reset();

    // Reset, then idle: pin stays low.
    do_reset();
    repeat (100) tick();

    // 0 -> 15: busy for exactly 30 clocks, then constant high.
    send(15);
    cnt = int'(busy);
    repeat (39) begin tick(); cnt += int'(busy); end
    check("busy_len_up", cnt, 30);
    repeat (20) tick();
    cnt = 0;
    repeat (PER) begin tick(); cnt += int'(led_pwm); end
    check("full_on_highs", cnt, 15);

    // Hold at 5: exactly 5 high clocks per period.
    send(5);
    wait_idle();
    repeat (30) tick();
    cnt = 0;
    repeat (PER) begin tick(); cnt += int'(led_pwm); end
    check("duty5_highs", cnt, 5);

    // Command 3 while ramping 0->10 is refused until the ramp ends, then ramps down in 14.
    send(0);
    wait_idle();
    send(10);
    cmd_valid = 1'b1;
    cmd_level = 4'd3;
    for (int i = 0; i < 60 && busy; i++) tick();
    check("ramp_end_level", int'(level), 10);
    tick();
    cmd_valid = 1'b0;
    cnt = int'(busy);
    repeat (30) begin tick(); cnt += int'(busy); end
    check("busy_len_down", cnt, 14);

    // Equal-level command: accepted, no ramp.
    send(7);
    wait_idle();
    repeat (20) tick();
    send(7);
    check("same_level_busy", int'(busy), 0);
    check("same_level_val", int'(level), 7);
    repeat (PER) tick();

    // Asynchronous reset mid-ramp at level 6.
    do_reset();
    send(15);
    for (int i = 0; i < 60 && level != 4'd6; i++) tick();
    check("pre_rst_level", int'(level), 6);
    #2;
    rst = 1'b1;
    #1;
    check("async_level", int'(level), 0);
    check("async_busy", int'(busy), 0);
    check("async_ready", int'(cmd_ready), 1);
    check("async_led", int'(led_pwm), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) tick();

`ifdef LIGHT_PWM_BLINK_EN
    send(15);
    wait_idle();
    repeat (20) tick();
    blink = 1'b1;
    cnt = 0;
    repeat (16) begin tick(); cnt += int'(led_pwm); end
    check("blink_highs", cnt, 8);
    blink = 1'b0;
    repeat (5) tick();
`endif

    // Randomised commands checked every clock against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_level = 4'($urandom_range(0, 15));
      tick();
    end
    cmd_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
